pixel_arbiter: RTL

Merges the pixel streams of several independent drawing engines (stair rectangles, player sprite, erase passes) into the single x/y/colour/plot stream that the VGA adapter consumes. It sits directly downstream of the stair datapaths and upstream of the frame-buffer write port. Each source emits one rectangle, or "packet", as a burst of pixels. The arbiter grants one source at a time with round-robin fairness and holds the grant until that source's last pixel. It also clips off-screen pixels, since the stair y counter wraps near the bottom edge and can produce y ≥ 120.

---
 rtl/pixel_arbiter_pkg.sv | 24 ++
 rtl/pixel_arbiter_if.sv | 36 +++
 rtl/pixel_arbiter_rr_picker.sv | 31 +++
 rtl/pixel_arbiter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/pixel_arbiter_pkg.sv
// Shared screen geometry, default field widths, arbiter state encoding and the clip test.
package pixel_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int X_W_DEF = 8;
  localparam int Y_W_DEF = 7;
  localparam int C_W_DEF = 3;

  // Coordinates are widened to this before comparing so any X_W/Y_W up to 16 works.
  localparam int COORD_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic on_screen(input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y);
    return (x < COORD_W'(SCREEN_W)) && (y < COORD_W'(SCREEN_H));
  endfunction

endpackage

// File: rtl/pixel_arbiter_if.sv
// Source-side pixel handshake plus the merged VGA pixel stream and status of the arbiter.
// master = drawing sources / VGA consumer side, slave = the arbiter.
interface pixel_arbiter_if
  import pixel_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int X_W   = X_W_DEF,
  parameter int Y_W   = Y_W_DEF,
  parameter int C_W   = C_W_DEF
);

  logic [N_SRC-1:0]     src_valid;
  logic [N_SRC-1:0]     src_last;
  logic [N_SRC*X_W-1:0] src_x;
  logic [N_SRC*Y_W-1:0] src_y;
  logic [N_SRC*C_W-1:0] src_colour;
  logic [N_SRC-1:0]     src_ready;

  logic [X_W-1:0]       out_x;
  logic [Y_W-1:0]       out_y;
  logic [C_W-1:0]       out_colour;
  logic                 out_plot;
  logic                 busy;
  logic [7:0]           clip_count;

  modport master (
    output src_valid, src_last, src_x, src_y, src_colour,
    input  src_ready, out_x, out_y, out_colour, out_plot, busy, clip_count
  );

  modport slave (
    input  src_valid, src_last, src_x, src_y, src_colour,
    output src_ready, out_x, out_y, out_colour, out_plot, busy, clip_count
  );

endinterface

// File: rtl/pixel_arbiter_rr_picker.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping N_SRC-1 -> 0.
// Returns the winner one-hot and as a binary index; all-zero one-hot means no request.
module rr_picker #(
  parameter int N_SRC = 4,
  localparam int IW   = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_SRC-1:0] gnt_oh_o,
  output logic [IW-1:0]    gnt_idx_o
);

  int   cand;
  logic found;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 0; i < N_SRC; i++) begin
      cand = (int'(ptr_i) + i) % N_SRC;
      if (!found && req_i[cand]) begin
        found           = 1'b1;
        gnt_oh_o[cand]  = 1'b1;
        gnt_idx_o       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/pixel_arbiter.sv
// Round-robin merge of N_SRC pixel bursts into one registered x/y/colour/plot stream.
// Accept-to-plot is one cycle; only the granted source sees src_ready, held until its last pixel.
module pixel_arbiter
  import pixel_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int X_W   = X_W_DEF,
  parameter int Y_W   = Y_W_DEF,
  parameter int C_W   = C_W_DEF
) (
  input logic            clock,
  input logic            reset_n,
  pixel_arbiter_if.slave bus
);

  localparam int            IW       = $clog2(N_SRC);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_SRC - 1);

  state_e         state_q, state_d;
  logic [IW-1:0]  grant_q, grant_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;

  logic [X_W-1:0] out_x_q;
  logic [Y_W-1:0] out_y_q;
  logic [C_W-1:0] out_colour_q;
  logic           out_plot_q;
  logic [7:0]     clip_count_q;

  logic [N_SRC-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic [N_SRC-1:0] src_ready;
  logic             busy;

  logic           accept;
  logic           accept_last;
  logic [X_W-1:0] sel_x;
  logic [Y_W-1:0] sel_y;
  logic [C_W-1:0] sel_colour;
  logic           sel_on;

  rr_picker #(.N_SRC(N_SRC)) u_rr_picker (
    .req_i     (bus.src_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx)
  );

  assign sel_x       = bus.src_x[grant_q*X_W +: X_W];
  assign sel_y       = bus.src_y[grant_q*Y_W +: Y_W];
  assign sel_colour  = bus.src_colour[grant_q*C_W +: C_W];
  assign sel_on      = on_screen(COORD_W'(sel_x), COORD_W'(sel_y));
  assign accept      = bus.src_valid[grant_q] & src_ready[grant_q];
  assign accept_last = accept & bus.src_last[grant_q];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (|pick_oh) begin
          grant_d = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A dropped valid mid-packet keeps the grant; only an accepted last pixel releases it.
        if (accept_last) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    src_ready = '0;
    busy      = 1'b0;
    if (state_q == GRANT) begin
      src_ready[grant_q] = 1'b1;
      busy               = 1'b1;
    end
  end

  // Off-screen pixels still update the coordinate registers but never raise plot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_colour_q <= '0;
      out_plot_q   <= 1'b0;
      clip_count_q <= '0;
    end else begin
      out_plot_q <= accept & sel_on;
      if (accept) begin
        out_x_q      <= sel_x;
        out_y_q      <= sel_y;
        out_colour_q <= sel_colour;
        if (!sel_on && (clip_count_q != 8'hFF)) begin
          clip_count_q <= clip_count_q + 8'd1;
        end
      end
    end
  end

  assign bus.src_ready  = src_ready;
  assign bus.busy       = busy;
  assign bus.out_x      = out_x_q;
  assign bus.out_y      = out_y_q;
  assign bus.out_colour = out_colour_q;
  assign bus.out_plot   = out_plot_q;
  assign bus.clip_count = clip_count_q;

endmodule
